// File: rtl/sb_drain_unit_pkg.sv
// sb_drain_unit_pkg: shared types for the store-buffer drain unit.
//   drain_state_e : drain FSM states (idle / request / waiting for response)
//   sb_entry_t    : committed store-buffer entry as it leaves the SB FIFO
package sb_drain_unit_pkg;
  localparam int SB_ADDR_WIDTH = 32;
  localparam int SB_DATA_WIDTH = 32;
  localparam int SB_STRB_WIDTH = SB_DATA_WIDTH / 8;
  typedef enum logic [1:0] {
    DRAIN_IDLE,
    DRAIN_REQ,
    DRAIN_RESP
  } drain_state_e;
  typedef struct packed {
    logic [SB_ADDR_WIDTH-1:0] target_addr;
    logic [SB_DATA_WIDTH-1:0] write_data;
    logic [SB_STRB_WIDTH-1:0] wstrb;
    logic                     valid;
    logic                     commit;
  } sb_entry_t;
endpackage

// File: rtl/sb_byte_merge.sv
// sb_byte_merge: combinational byte-enable merge of a new store into a held store.
//   old_data/old_strb : held store
//   new_data/new_strb : incoming store to the same word
//   data/strb         : merged store (new bytes win, enables OR-ed)
// Only built when SB_DRAIN_MERGE_EN is defined, since only then is it instantiated.
`ifdef SB_DRAIN_MERGE_EN
module sb_byte_merge
  import sb_drain_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_data,
  input  logic [DATA_WIDTH/8-1:0] old_strb,
  input  logic [DATA_WIDTH-1:0]   new_data,
  input  logic [DATA_WIDTH/8-1:0] new_strb,
  output logic [DATA_WIDTH-1:0]   data,
  output logic [DATA_WIDTH/8-1:0] strb
);
  for (genvar b = 0; b < DATA_WIDTH / 8; b++) begin : g_byte
    assign data[8*b +: 8] = new_strb[b] ? new_data[8*b +: 8] : old_data[8*b +: 8];
  end
  assign strb = old_strb | new_strb;
endmodule
`endif

// File: rtl/sb_drain_unit.sv
// sb_drain_unit: drains committed store-buffer entries into the data-memory write port.
// Ports:
//   clk, rst_n                           clock, synchronous active-low reset
//   sb_entry_valid/ready/addr/data/strb  receiver handshake from the SB FIFO
//   wr_req_valid_o/ready_i               write request handshake
//   wr_addr_o/data_o/strb_o              write payload (address word-aligned)
//   wr_resp_valid_i/err_i                write completion
//   busy_o                               work held or in flight
//   err_o                                sticky errored completion
//   store_cnt_o                          completed writes, wrapping
// Optional feature: define SB_DRAIN_MERGE_EN to merge same-word stores into the hold stage.
module sb_drain_unit
  import sb_drain_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sb_entry_valid,
  output logic                    sb_entry_ready,
  input  logic [ADDR_WIDTH-1:0]   sb_entry_addr,
  input  logic [DATA_WIDTH-1:0]   sb_entry_data,
  input  logic [DATA_WIDTH/8-1:0] sb_entry_strb,
  output logic                    wr_req_valid_o,
  input  logic                    wr_req_ready_i,
  output logic [ADDR_WIDTH-1:0]   wr_addr_o,
  output logic [DATA_WIDTH-1:0]   wr_data_o,
  output logic [DATA_WIDTH/8-1:0] wr_strb_o,
  input  logic                    wr_resp_valid_i,
  input  logic                    wr_resp_err_i,
  output logic                    busy_o,
  output logic                    err_o,
  output logic [CNT_WIDTH-1:0]    store_cnt_o
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  drain_state_e            state;
  logic                    hold_v;
  logic [ADDR_WIDTH-1:0]   hold_addr;
  logic [DATA_WIDTH-1:0]   hold_data;
  logic [STRB_WIDTH-1:0]   hold_strb;
  logic                    req_fire;
  logic                    accept;
  logic                    match;
  logic [DATA_WIDTH-1:0]   merge_data;
  logic [STRB_WIDTH-1:0]   merge_strb;
`ifdef SB_DRAIN_MERGE_EN
  // Never merge while the hold drives a pending request: its payload must stay stable.
  assign match = hold_v && state != DRAIN_REQ &&
                 sb_entry_addr[ADDR_WIDTH-1:2] == hold_addr[ADDR_WIDTH-1:2];
  sb_byte_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
    .old_data(hold_data),
    .old_strb(hold_strb),
    .new_data(sb_entry_data),
    .new_strb(sb_entry_strb),
    .data    (merge_data),
    .strb    (merge_strb)
  );
`else
  assign match      = 1'b0;
  assign merge_data = '0;
  assign merge_strb = '0;
`endif
  assign req_fire       = state == DRAIN_REQ && wr_req_ready_i;
  // The hold frees up on the request handshake, so a new entry may be taken that same cycle.
  assign sb_entry_ready = !hold_v || req_fire || match;
  assign accept         = sb_entry_valid && sb_entry_ready;
  assign wr_req_valid_o = state == DRAIN_REQ;
  assign wr_addr_o      = hold_addr & ~ADDR_WIDTH'(3);
  assign wr_data_o      = hold_data;
  assign wr_strb_o      = hold_strb;
  assign busy_o         = hold_v || state != DRAIN_IDLE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= DRAIN_IDLE;
      hold_v      <= 1'b0;
      hold_addr   <= '0;
      hold_data   <= '0;
      hold_strb   <= '0;
      err_o       <= 1'b0;
      store_cnt_o <= '0;
    end else begin
      if (accept) begin
        hold_v    <= 1'b1;
        hold_addr <= match ? hold_addr : sb_entry_addr;
        hold_data <= match ? merge_data : sb_entry_data;
        hold_strb <= match ? merge_strb : sb_entry_strb;
      end else if (req_fire) begin
        hold_v <= 1'b0;
      end
      case (state)
        DRAIN_IDLE: state <= hold_v ? DRAIN_REQ : DRAIN_IDLE;
        DRAIN_REQ:  state <= wr_req_ready_i ? DRAIN_RESP : DRAIN_REQ;
        DRAIN_RESP: begin
          // Look at the hold as it will be next cycle so a same-cycle refill issues without a bubble.
          if (wr_resp_valid_i) begin
            state       <= (hold_v || accept) ? DRAIN_REQ : DRAIN_IDLE;
            store_cnt_o <= store_cnt_o + CNT_WIDTH'(1);
            err_o       <= err_o | wr_resp_err_i;
          end
        end
        default: state <= DRAIN_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sb_drain_unit.sv
// tb_sb_drain_unit: directed self-checking bench for sb_drain_unit.
module tb_sb_drain_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        sb_entry_valid;
  logic        sb_entry_ready;
  logic [31:0] sb_entry_addr;
  logic [31:0] sb_entry_data;
  logic [3:0]  sb_entry_strb;
  logic        wr_req_valid_o;
  logic        wr_req_ready_i;
  logic [31:0] wr_addr_o;
  logic [31:0] wr_data_o;
  logic [3:0]  wr_strb_o;
  logic        wr_resp_valid_i;
  logic        wr_resp_err_i;
  logic        busy_o;
  logic        err_o;
  logic [31:0] store_cnt_o;
  int          total = 0;
  int          passed = 0;
  logic [31:0] exp_cnt = 0;
  logic        exp_err = 0;

  always #5 clk = ~clk;

  sb_drain_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sb_entry_valid (sb_entry_valid),
    .sb_entry_ready (sb_entry_ready),
    .sb_entry_addr  (sb_entry_addr),
    .sb_entry_data  (sb_entry_data),
    .sb_entry_strb  (sb_entry_strb),
    .wr_req_valid_o (wr_req_valid_o),
    .wr_req_ready_i (wr_req_ready_i),
    .wr_addr_o      (wr_addr_o),
    .wr_data_o      (wr_data_o),
    .wr_strb_o      (wr_strb_o),
    .wr_resp_valid_i(wr_resp_valid_i),
    .wr_resp_err_i  (wr_resp_err_i),
    .busy_o         (busy_o),
    .err_o          (err_o),
    .store_cnt_o    (store_cnt_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic entry(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    sb_entry_valid = v;
    sb_entry_addr  = a;
    sb_entry_data  = d;
    sb_entry_strb  = s;
  endtask

  task automatic resp(input logic v, input logic e);
    wr_resp_valid_i = v;
    wr_resp_err_i   = e;
  endtask

  // Three stores; each later store is presented in the same cycle as the previous response.
  task automatic three_stores(input logic [31:0] base, input logic [2:0] errs);
    entry(1, base, base ^ 32'hA5A5_0000, 4'hF);
    tick();
    entry(0, 0, 0, 0);
    tick();
    chk("b2b_req0_valid", wr_req_valid_o, 1);
    chk("b2b_req0_addr", wr_addr_o, base);
    tick();
    for (int k = 0; k < 3; k++) begin
      if (k < 2) entry(1, base + 32'(4 * (k + 1)), (base + 32'(4 * (k + 1))) ^ 32'hA5A5_0000, 4'hF);
      resp(1, errs[k]);
      tick();
      resp(0, 0);
      entry(0, 0, 0, 0);
      exp_cnt = exp_cnt + 1;
      exp_err = exp_err | errs[k];
      chk("b2b_cnt", store_cnt_o, exp_cnt);
      chk("b2b_err", err_o, exp_err);
      if (k < 2) begin
        chk("b2b_next_valid", wr_req_valid_o, 1);
        chk("b2b_next_addr", wr_addr_o, base + 32'(4 * (k + 1)));
        chk("b2b_next_data", wr_data_o, (base + 32'(4 * (k + 1))) ^ 32'hA5A5_0000);
        tick();
        chk("b2b_resp_wait", wr_req_valid_o, 0);
      end else begin
        chk("b2b_done_valid", wr_req_valid_o, 0);
        chk("b2b_done_busy", busy_o, 0);
      end
    end
  endtask

  initial begin
    rst_n = 0;
    entry(0, 0, 0, 0);
    resp(0, 0);
    wr_req_ready_i = 0;
    tick();
    tick();
    chk("rst_valid", wr_req_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_cnt", store_cnt_o, 0);
    chk("rst_addr", wr_addr_o, 0);
    chk("rst_data", wr_data_o, 0);
    chk("rst_strb", wr_strb_o, 0);
    rst_n = 1;

    // single store
    wr_req_ready_i = 1;
    entry(1, 32'h1000, 32'hDEAD_BEEF, 4'hF);
    tick();
    entry(0, 0, 0, 0);
    chk("t1_no_req_yet", wr_req_valid_o, 0);
    chk("t1_busy_hold", busy_o, 1);
    tick();
    chk("t1_req_valid", wr_req_valid_o, 1);
    chk("t1_addr", wr_addr_o, 32'h1000);
    chk("t1_data", wr_data_o, 32'hDEAD_BEEF);
    chk("t1_strb", wr_strb_o, 4'hF);
    tick();
    chk("t1_resp_wait", wr_req_valid_o, 0);
    chk("t1_busy_resp", busy_o, 1);
    tick();
    resp(1, 0);
    tick();
    resp(0, 0);
    exp_cnt = 1;
    chk("t1_cnt", store_cnt_o, exp_cnt);
    chk("t1_busy_after", busy_o, 0);
    chk("t1_err", err_o, 0);

    // memory stall, unaligned address forced to word alignment
    wr_req_ready_i = 0;
    entry(1, 32'h1007, 32'h1122_3344, 4'h3);
    tick();
    entry(0, 0, 0, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t2_stall_valid", wr_req_valid_o, 1);
      chk("t2_stall_addr", wr_addr_o, 32'h1004);
      chk("t2_stall_data", wr_data_o, 32'h1122_3344);
      chk("t2_stall_strb", wr_strb_o, 4'h3);
      tick();
    end
    wr_req_ready_i = 1;
    chk("t2_accept_valid", wr_req_valid_o, 1);
    tick();
    chk("t2_after_accept", wr_req_valid_o, 0);
    resp(1, 0);
    tick();
    resp(0, 0);
    exp_cnt = 2;
    chk("t2_cnt", store_cnt_o, exp_cnt);
    chk("t2_idle", busy_o, 0);

    // back-to-back, no errors, then error on the second of three
    three_stores(32'h3000, 3'b000);
    three_stores(32'h4000, 3'b010);

    // same-word stores arriving while a write is outstanding
    entry(1, 32'h5000, 32'h1111_1111, 4'hF);
    tick();
    entry(0, 0, 0, 0);
    tick();
    tick();
    entry(1, 32'h2000, 32'h0000_00AA, 4'b0001);
    tick();
    entry(1, 32'h2002, 32'h00BB_0000, 4'b0100);
`ifdef SB_DRAIN_MERGE_EN
    chk("m_merge_ready", sb_entry_ready, 1);
    tick();
    entry(0, 0, 0, 0);
    resp(1, 0);
    tick();
    resp(0, 0);
    chk("m_req_valid", wr_req_valid_o, 1);
    chk("m_addr", wr_addr_o, 32'h2000);
    chk("m_data", wr_data_o, 32'h00BB_00AA);
    chk("m_strb", wr_strb_o, 4'b0101);
    tick();
    resp(1, 0);
    tick();
    resp(0, 0);
    exp_cnt = exp_cnt + 2;
    chk("m_cnt", store_cnt_o, exp_cnt);
    chk("m_single_write", busy_o, 0);
`else
    chk("nm_ready_low", sb_entry_ready, 0);
    tick();
    resp(1, 0);
    tick();
    resp(0, 0);
    chk("nm_req_a_valid", wr_req_valid_o, 1);
    chk("nm_req_a_data", wr_data_o, 32'h0000_00AA);
    chk("nm_req_a_strb", wr_strb_o, 4'b0001);
    chk("nm_refill_ready", sb_entry_ready, 1);
    tick();
    entry(0, 0, 0, 0);
    chk("nm_resp_wait", wr_req_valid_o, 0);
    chk("nm_hold_busy", busy_o, 1);
    resp(1, 0);
    tick();
    resp(0, 0);
    chk("nm_req_b_valid", wr_req_valid_o, 1);
    chk("nm_req_b_addr", wr_addr_o, 32'h2000);
    chk("nm_req_b_data", wr_data_o, 32'h00BB_0000);
    chk("nm_req_b_strb", wr_strb_o, 4'b0100);
    tick();
    resp(1, 0);
    tick();
    resp(0, 0);
    exp_cnt = exp_cnt + 3;
    chk("nm_cnt", store_cnt_o, exp_cnt);
    chk("nm_idle", busy_o, 0);
`endif

    // reset while a response is outstanding and the hold is full
    entry(1, 32'h6000, 32'hCAFE_F00D, 4'hF);
    tick();
    entry(0, 0, 0, 0);
    tick();
    tick();
    entry(1, 32'h6004, 32'h1234_5678, 4'hC);
    tick();
    entry(0, 0, 0, 0);
    chk("t6_pre_busy", busy_o, 1);
    rst_n = 0;
    tick();
    chk("t6_valid", wr_req_valid_o, 0);
    chk("t6_busy", busy_o, 0);
    chk("t6_err", err_o, 0);
    chk("t6_cnt", store_cnt_o, 0);
    chk("t6_addr", wr_addr_o, 0);
    chk("t6_data", wr_data_o, 0);
    chk("t6_strb", wr_strb_o, 0);
    rst_n = 1;
    tick();
    resp(1, 1);
    tick();
    resp(0, 0);
    chk("t6_stray_cnt", store_cnt_o, 0);
    chk("t6_stray_err", err_o, 0);
    chk("t6_stray_busy", busy_o, 0);
    chk("t6_stray_valid", wr_req_valid_o, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
